// File: rtl/dcache_line_memory.sv
// Line-granular backing store for the data cache: one outstanding refill/write-back,
// fixed LATENCY-cycle turnaround, single-cycle ack pulse.
module dcache_line_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] dat_q;
    logic [LINE_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx_in;
    logic [IDX_W-1:0]  rd_idx;
    logic              op_wr;
    logic              enter_ack;
    logic              unused_addr;

    assign idx_in      = addr_i[5 +: IDX_W];
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    // With LATENCY=1 the ACK state is entered straight from IDLE, so the
    // read index must come from the live address rather than the latch.
    assign enter_ack = (state == IDLE && req_i && LATENCY == 1) ||
                       (state == WAIT && cnt == CNT_W'(1));
    assign rd_idx    = (state == IDLE) ? idx_in  : idx_q;
    assign op_wr     = (state == IDLE) ? write_i : wr_q;

    assign ack_o  = (state == ACK);
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_q   <= 1'b0;
            idx_q  <= '0;
            dat_q  <= '0;
            data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        wr_q  <= write_i;
                        idx_q <= idx_in;
                        dat_q <= data_i;
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= (LATENCY == 1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_ack && !op_wr) begin
                data_o <= mem[rd_idx];
            end
        end
    end

    // Array is deliberately left out of reset; a write aborted by reset never lands.
    always_ff @(posedge clk_i) begin
        if (state == ACK && wr_q) begin
            mem[idx_q] <= dat_q;
        end
    end

endmodule

// File: tb/tb_dcache_line_memory.sv
// Scoreboard bench for dcache_line_memory: LATENCY=10 and LATENCY=1 instances,
// directed cases plus randomized traffic against a line-array reference model.
module tb_dcache_line_memory;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         rst;
    logic         req   [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] din   [2];
    logic [255:0] dout  [2];
    logic         ack   [2];
    logic         busy  [2];

    always #5 clk = ~clk;

    dcache_line_memory #(.LATENCY(10), .DEPTH(DEPTH), .LINE_W(256)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .write_i(wr[0]), .addr_i(addr[0]),
        .data_i(din[0]), .ack_o(ack[0]), .data_o(dout[0]), .busy_o(busy[0]));

    dcache_line_memory #(.LATENCY(1), .DEPTH(DEPTH), .LINE_W(256)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .write_i(wr[1]), .addr_i(addr[1]),
        .data_i(din[1]), .ack_o(ack[1]), .data_o(dout[1]), .busy_o(busy[1]));

    typedef struct {
        int           inst;
        longint       acc;
        bit           w;
        int           idx;
        logic [255:0] dat;
    } exp_t;

    exp_t         sq [$];
    logic [255:0] mm [2][DEPTH];
    logic [255:0] exp_dout [2];
    longint       cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int i);
        return (i == 0) ? 10 : 1;
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'(a[13:5]);
    endfunction

    function automatic bit pending(int i);
        foreach (sq[k]) if (sq[k].inst == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] mkaddr(int idx);
        logic [31:0] a;
        a = $urandom;
        a[13:5] = 9'(idx);
        return a;
    endfunction

    task automatic chk(string nm, int i, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %h want %h", nm, i, cyc, act, exp);
        end
    endtask

    // Monitor: model says when each accepted request must ack and what it returns.
    task automatic monitor_one(int i);
        int  k;
        bit  eack;
        bit  ebusy;
        k = -1;
        eack = 1'b0;
        ebusy = 1'b0;
        foreach (sq[j]) if (k < 0 && sq[j].inst == i) k = j;
        if (k >= 0) begin
            ebusy = (cyc >= sq[k].acc);
            eack  = (cyc == sq[k].acc + lat(i) - 1);
            if (cyc >= sq[k].acc + lat(i) - 1) begin
                if (sq[k].w) mm[i][sq[k].idx] = sq[k].dat;
                else         exp_dout[i] = sq[k].dat;
                sq.delete(k);
            end
        end
        chk("ack", i, 256'(ack[i]), 256'(eack));
        chk("busy", i, 256'(busy[i]), 256'(ebusy));
        chk("data_o", i, dout[i], exp_dout[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) monitor_one(i);
        end
    end

    task automatic push(int i, longint acc, bit w, logic [31:0] a, logic [255:0] d);
        exp_t e;
        e.inst = i;
        e.acc  = acc;
        e.w    = w;
        e.idx  = idx_of(a);
        e.dat  = w ? d : mm[i][idx_of(a)];
        sq.push_back(e);
    endtask

    task automatic wait_idle(int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pending(i) || busy[i]) && n < 400);
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_timeout inst%0d busy %0d want 0", i, busy[i]);
            for (int k = sq.size() - 1; k >= 0; k--) if (sq[k].inst == i) sq.delete(k);
        end
    endtask

    task automatic issue(int i, bit w, logic [31:0] a, logic [255:0] d, bit toggle);
        int n;
        @(negedge clk);
        req[i] = 1'b1; wr[i] = w; addr[i] = a; din[i] = d;
        push(i, cyc + 1, w, a, d);
        @(negedge clk);
        n = 0;
        while (toggle && pending(i) && n < 300) begin
            req[i]  = 1'($urandom_range(0, 1));
            wr[i]   = 1'($urandom_range(0, 1));
            addr[i] = $urandom;
            din[i]  = rnd256();
            n++;
            @(negedge clk);
        end
        req[i] = 1'b0;
        wait_idle(i);
    endtask

    // Two reads with req held high throughout: second accepted at t+LATENCY+1.
    task automatic b2b(int i, logic [31:0] a1, logic [31:0] a2);
        longint t;
        @(negedge clk);
        req[i] = 1'b1; wr[i] = 1'b0; addr[i] = a1;
        t = cyc + 1;
        push(i, t, 1'b0, a1, '0);
        push(i, t + lat(i) + 1, 1'b0, a2, '0);
        @(negedge clk);
        addr[i] = a2;
        for (int n = 0; n < 100 && cyc < t + lat(i) + 1; n++) @(negedge clk);
        req[i] = 1'b0;
        wait_idle(i);
    endtask

    int pool [8];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
            exp_dout[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(0, 1'b1, 32'h60, {8{32'hDEADBEEF}}, 1'b0);
        issue(0, 1'b0, 32'h60, '0, 1'b0);

        issue(0, 1'b1, 32'h3FE0, {8{32'h12345678}}, 1'b0);
        issue(0, 1'b0, 32'h3FE0, '0, 1'b0);
        issue(0, 1'b0, 32'h7FE0, '0, 1'b0);

        issue(0, 1'b1, 32'h20, rnd256(), 1'b0);
        issue(0, 1'b1, 32'h40, rnd256(), 1'b0);
        b2b(0, 32'h20, 32'h40);

        issue(0, 1'b1, 32'h3FE0, rnd256(), 1'b1);
        issue(0, 1'b0, 32'h7FE0, '0, 1'b1);

        // Write aborted mid-flight by reset; line 7 must keep its prior value.
        issue(0, 1'b1, 32'hE0, rnd256(), 1'b0);
        issue(0, 1'b0, 32'h60, '0, 1'b0);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'hE0; din[0] = '1;
        push(0, cyc + 1, 1'b1, 32'hE0, '1);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_ack", 0, 256'(ack[0]), 256'(0));
        chk("rst_busy", 0, 256'(busy[0]), 256'(0));
        chk("rst_data_o", 0, dout[0], '0);
        sq.delete();
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(0, 1'b0, 32'hE0, '0, 1'b0);

        issue(1, 1'b1, 32'h100, rnd256(), 1'b0);
        issue(1, 1'b0, 32'h100, '0, 1'b0);
        issue(1, 1'b1, 32'h20, rnd256(), 1'b0);
        issue(1, 1'b1, 32'h40, rnd256(), 1'b0);
        b2b(1, 32'h20, 32'h40);

        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 8; p++) begin
                pool[p] = $urandom_range(0, DEPTH - 1);
                issue(i, 1'b1, mkaddr(pool[p]), rnd256(), 1'b0);
            end
            for (int n = 0; n < 40; n++) begin
                issue(i, 1'($urandom_range(0, 1)), mkaddr(pool[$urandom_range(0, 7)]),
                      rnd256(), ($urandom_range(0, 2) == 0));
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
